// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC and buffers {PC+4, instr} pairs ahead of decode.
// Optional empty-queue bypass compiled in with FETCHQ_BYPASS_EN.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_redirect,
    input  logic [31:0]              i_redirect_pc,
    input  logic                     i_stall,
    output logic [31:0]              o_imem_addr,
    input  logic [31:0]              i_imem_data,
    output logic                     o_instr_valid,
    output logic [31:0]              o_instr,
    output logic [31:0]              o_pc_plus4,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [31:0]   r_fpc;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pcp4  [DEPTH];

    logic [31:0]   w_fpc_plus4;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_bypass;

    assign w_fpc_plus4 = r_fpc + 32'd4;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_COUNT);
    assign w_pop       = !w_empty && !i_stall && !i_redirect;

`ifdef FETCHQ_BYPASS_EN
    // Word goes straight to decode without occupying a slot.
    assign w_bypass = w_empty && !i_stall && !i_redirect;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = !i_redirect && !w_bypass && (!w_full || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fpc    <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_pcp4[i]  <= '0;
            end
        end else if (i_redirect) begin
            r_fpc    <= {i_redirect_pc[31:2], 2'b00};
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_instr[r_wr_ptr] <= i_imem_data;
                r_pcp4[r_wr_ptr]  <= w_fpc_plus4;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push || w_bypass) begin
                r_fpc <= w_fpc_plus4;
            end
        end
    end

    assign o_imem_addr = r_fpc;
    assign o_count     = r_count;

    always_comb begin
        o_instr_valid = !w_empty && !i_redirect && !i_rst;
        o_instr       = w_empty ? 32'd0 : r_instr[r_rd_ptr];
        o_pc_plus4    = w_empty ? 32'd0 : r_pcp4[r_rd_ptr];
`ifdef FETCHQ_BYPASS_EN
        if (w_empty && !i_redirect && !i_rst) begin
            o_instr_valid = 1'b1;
            o_instr       = i_imem_data;
            o_pc_plus4    = w_fpc_plus4;
        end
`endif
    end

endmodule
